// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 256Kx16 SRAM between recorder writes and player reads.
// Config macro: SRAM_ARB_REC_PRIO_EN (fixed recorder priority; default round robin).
// Ports:
//   bclk, rst                     clock, async active-high reset
//   rec_req/addr/wdata, rec_ack   recorder write handshake
//   play_req/addr, play_rdata/ack player read handshake
//   sram_addr, sram_dq_i/o/oe     SRAM address and data bus
//   sram_ce_n/oe_n/we_n/ub_n/lb_n SRAM controls, active-low
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        bclk,
  input  logic        rst,
  input  logic        rec_req,
  input  logic [17:0] rec_addr,
  input  logic [15:0] rec_wdata,
  output logic        rec_ack,
  input  logic        play_req,
  input  logic [17:0] play_addr,
  output logic [15:0] play_rdata,
  output logic        play_ack,
  output logic [17:0] sram_addr,
  input  logic [15:0] sram_dq_i,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       wr, wr_nxt;
  logic       grant;
  logic       pick_rec;
  logic       ce_nxt, oe_nxt, we_nxt, dqoe_nxt;
  logic       rec_ack_nxt, play_ack_nxt;

`ifdef SRAM_ARB_REC_PRIO_EN
  assign pick_rec = rec_req;
`else
  logic lg_play;

  // On a conflict the side that did not win last time gets the bus.
  assign pick_rec = rec_req & (~play_req | lg_play);
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    wr_nxt       = wr;
    grant        = 1'b0;
    rec_ack_nxt  = 1'b0;
    play_ack_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (rec_req | play_req) begin
          grant     = 1'b1;
          wr_nxt    = pick_rec;
          cnt_nxt   = 4'd0;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == LAST) begin
          state_nxt    = ACK;
          rec_ack_nxt  = wr;
          play_ack_nxt = ~wr;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Pin values are computed for the coming cycle so every pin is a flop.
    ce_nxt   = (state_nxt != ACCESS);
    oe_nxt   = ~((state_nxt == ACCESS) & ~wr_nxt);
    dqoe_nxt = (state_nxt == ACCESS) & wr_nxt;
    // Last write cycle keeps data on the bus with we_n already high.
    we_nxt   = ~(dqoe_nxt & (cnt_nxt != LAST));
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      wr         <= 1'b0;
      rec_ack    <= 1'b0;
      play_ack   <= 1'b0;
      play_rdata <= 16'h0;
      sram_addr  <= 18'h0;
      sram_dq_o  <= 16'h0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      wr         <= wr_nxt;
      rec_ack    <= rec_ack_nxt;
      play_ack   <= play_ack_nxt;
      sram_dq_oe <= dqoe_nxt;
      sram_ce_n  <= ce_nxt;
      sram_oe_n  <= oe_nxt;
      sram_we_n  <= we_nxt;
      sram_ub_n  <= ce_nxt;
      sram_lb_n  <= ce_nxt;
      if (grant) begin
        sram_addr <= pick_rec ? rec_addr : play_addr;
        if (pick_rec) sram_dq_o <= rec_wdata;
      end
      if (play_ack_nxt) play_rdata <= sram_dq_i;
    end
  end

`ifndef SRAM_ARB_REC_PRIO_EN
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      lg_play <= 1'b0;
    end else if (grant) begin
      lg_play <= ~pick_rec;
    end
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: vector table plus hand sequences for sram_arbiter.
// Ack order, timing and read data are scored against a queue.
module tb_sram_arbiter;

  localparam int AC = 2;

  logic        bclk = 1'b0;
  logic        rst;
  logic        rec_req, play_req;
  logic [17:0] rec_addr, play_addr;
  logic [15:0] rec_wdata;
  logic        rec_ack, play_ack;
  logic [15:0] play_rdata;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_i, sram_dq_o;
  logic        sram_dq_oe;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic        sram_ub_n, sram_lb_n;

  sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .bclk(bclk), .rst(rst),
    .rec_req(rec_req), .rec_addr(rec_addr),
    .rec_wdata(rec_wdata), .rec_ack(rec_ack),
    .play_req(play_req), .play_addr(play_addr),
    .play_rdata(play_rdata), .play_ack(play_ack),
    .sram_addr(sram_addr), .sram_dq_i(sram_dq_i),
    .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n)
  );

  always #5 bclk = ~bclk;

  logic [15:0] mem [0:262143];

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0;

  always @(posedge bclk)
    if (!sram_ce_n && !sram_we_n && sram_dq_oe)
      mem[sram_addr] <= sram_dq_o;

  typedef struct {
    bit          is_rec;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          is_rec;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_oe;
    int          exp_we;
    int          exp_dqoe;
  } vec_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_total = 0;
  int acks_exp = 0;
  int n_oe, n_we, n_dqoe;

  always @(posedge bclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge bclk) begin
    if (!rst) begin
      if (!sram_oe_n) n_oe++;
      if (!sram_we_n) n_we++;
      if (sram_dq_oe) n_dqoe++;
      if (rec_ack || play_ack) begin
        ack_total++;
        chk("ack_overlap", {31'd0, rec_ack & play_ack}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_kind", {31'd0, rec_ack}, {31'd0, e.is_rec});
          chk("ack_cycle", cyc, e.cyc);
          if (!e.is_rec) chk("play_rdata", {16'd0, play_rdata},
                             {16'd0, e.rdata});
        end
      end
    end
  end

  task automatic expect_txn(input bit is_rec, input logic [15:0] rdata,
                            input int offs);
    exp_t e;
    e.is_rec = is_rec;
    e.rdata  = rdata;
    e.cyc    = cyc + AC + offs;
    sb.push_back(e);
    acks_exp++;
  endtask

  // Drive one request in IDLE; returns #1 after the grant edge.
  task automatic issue(input bit is_rec, input logic [17:0] addr,
                       input logic [15:0] wdata, input logic [15:0] rdata);
    @(negedge bclk);
    #1;
    n_oe = 0;
    n_we = 0;
    n_dqoe = 0;
    if (is_rec) begin
      rec_addr = addr;
      rec_wdata = wdata;
      rec_req = 1'b1;
    end else begin
      play_addr = addr;
      play_req = 1'b1;
    end
    @(posedge bclk);
    #1;
    expect_txn(is_rec, rdata, 0);
  endtask

  task automatic wait_ack(input int target, input bit drop_rec,
                          input bit drop_play);
    int n = 0;
    while (ack_total < target && n < 40) begin
      @(negedge bclk);
      #1;
      n++;
    end
    if (ack_total < target) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got %0d acks expected %0d",
               ack_total, target);
      acks_exp = ack_total;
      sb.delete();
    end
    if (drop_rec) rec_req = 1'b0;
    if (drop_play) play_req = 1'b0;
  endtask

  vec_t vt[7];
  int   base;
  int   ntx;

  initial begin
    rst = 1'b1;
    rec_req = 1'b0;
    play_req = 1'b0;
    rec_addr = '0;
    play_addr = '0;
    rec_wdata = '0;
    mem[18'h00010] = 16'hBEEF;
    mem[18'h00020] = 16'h6666;
    mem[18'h00030] = 16'h7070;
    mem[18'h00100] = 16'hC0DE;

    vt[0] = '{0, 18'h00010, 16'h0,    16'hBEEF, AC, 0,      0};
    vt[1] = '{1, 18'h3FFFF, 16'h1234, 16'h0,    0,  AC - 1, AC};
    vt[2] = '{0, 18'h3FFFF, 16'h0,    16'h1234, AC, 0,      0};
    vt[3] = '{1, 18'h00000, 16'hA5A5, 16'h0,    0,  AC - 1, AC};
    vt[4] = '{0, 18'h00000, 16'h0,    16'hA5A5, AC, 0,      0};
    vt[5] = '{1, 18'h00010, 16'h0F0F, 16'h0,    0,  AC - 1, AC};
    vt[6] = '{0, 18'h00010, 16'h0,    16'h0F0F, AC, 0,      0};

    repeat (3) @(posedge bclk);
    #1;
    chk("rst_acks", {30'd0, rec_ack, play_ack}, 32'd0);
    chk("rst_rdata", {16'd0, play_rdata}, 32'd0);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_dq", {15'd0, sram_dq_o, sram_dq_oe}, 32'd0);
    chk("rst_ctl_n", {27'd0, sram_ce_n, sram_oe_n, sram_we_n,
                      sram_ub_n, sram_lb_n}, 32'h1F);
    @(negedge bclk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      issue(vt[i].is_rec, vt[i].addr, vt[i].wdata, vt[i].exp_rdata);
      wait_ack(acks_exp, 1'b1, 1'b1);
      chk($sformatf("v%0d_oe_cycles", i), n_oe, vt[i].exp_oe);
      chk($sformatf("v%0d_we_cycles", i), n_we, vt[i].exp_we);
      chk($sformatf("v%0d_dqoe_cycles", i), n_dqoe, vt[i].exp_dqoe);
      chk($sformatf("v%0d_addr", i), {14'd0, sram_addr},
          {14'd0, vt[i].addr});
      chk($sformatf("v%0d_ctl_idle", i), {29'd0, sram_ce_n,
          sram_oe_n, sram_we_n}, 32'h7);
      if (vt[i].is_rec)
        chk($sformatf("v%0d_mem", i), {16'd0, mem[vt[i].addr]},
            {16'd0, vt[i].wdata});
    end

    // Address change and request drop mid-ACCESS are ignored.
    issue(1'b0, 18'h00020, 16'h0, 16'h6666);
    play_addr = 18'h00030;
    play_req = 1'b0;
    @(negedge bclk);
    chk("hold_addr_acc1", {14'd0, sram_addr}, 32'h20);
    @(negedge bclk);
    chk("hold_addr_acc2", {14'd0, sram_addr}, 32'h20);
    wait_ack(acks_exp, 1'b1, 1'b1);
    chk("hold_addr_ack", {14'd0, sram_addr}, 32'h20);

    // Reset in the second ACCESS cycle of a write.
    @(negedge bclk);
    #1;
    rec_addr = 18'h00200;
    rec_wdata = 16'h5555;
    rec_req = 1'b1;
    @(posedge bclk);
    @(posedge bclk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_ctl_n", {27'd0, sram_ce_n, sram_oe_n, sram_we_n,
                        sram_ub_n, sram_lb_n}, 32'h1F);
    chk("abort_dqoe", {31'd0, sram_dq_oe}, 32'd0);
    chk("abort_ack", {31'd0, rec_ack}, 32'd0);
    rec_wdata = 16'h7777;
    @(negedge bclk);
    @(negedge bclk);
    #1;
    rst = 1'b0;
    @(posedge bclk);
    #1;
    expect_txn(1'b1, 16'h0, 0);
    wait_ack(acks_exp, 1'b1, 1'b1);
    chk("reissue_mem", {16'd0, mem[18'h00200]}, 32'h7777);

    // Both requesters held for a run of back-to-back transactions.
    @(negedge bclk);
    #1;
    rec_addr = 18'h00300;
    rec_wdata = 16'h3C3C;
    play_addr = 18'h00100;
    rec_req = 1'b1;
    play_req = 1'b1;
    @(posedge bclk);
    #1;
    base = ack_total;
`ifdef SRAM_ARB_REC_PRIO_EN
    ntx = 5;
    for (int i = 0; i < 4; i++) expect_txn(1'b1, 16'h0, i * (AC + 2));
    expect_txn(1'b0, 16'hC0DE, 4 * (AC + 2));
`else
    ntx = 4;
    for (int i = 0; i < 4; i++)
      expect_txn(i[0], 16'hC0DE, i * (AC + 2));
`endif
    for (int i = 0; i < ntx; i++) begin
      if (i == ntx - 1) wait_ack(base + i + 1, 1'b1, 1'b1);
      else if (i == 3) wait_ack(base + i + 1, 1'b1, 1'b0);
      else wait_ack(base + i + 1, 1'b0, 1'b0);
    end
    chk("rr_mem", {16'd0, mem[18'h00300]}, 32'h3C3C);

    repeat (6) @(negedge bclk);
    chk("sb_drained", sb.size(), 32'd0);
    chk("ack_count", ack_total, acks_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
